// File: rtl/ad_pulse_gen_pkg.sv
// Shared DSO definitions: pulse FSM state encoding, ADC width, default timeout.
package ad_pulse_gen_pkg;

   localparam int AD_DW       = 8;
   localparam int TIMEOUT_DEF = 1 << 20;

   typedef enum logic [1:0] {
      ST_LOW      = 2'd0,
      ST_RISE_CHK = 2'd1,
      ST_HIGH     = 2'd2,
      ST_FALL_CHK = 2'd3
   } pulse_state_t;

endpackage

// File: rtl/ad_pulse_gen.sv
// Debounced, hysteretic square-pulse extractor for the raw AD sample stream.
// Produces ad_pulse, a rise strobe, the period between rises and a no-signal flag.
//
// Handshake note: there is no valid/ready pairing here; ad_data is a sample
// every ad_clk cycle, and rise_stb / period_valid are single-cycle strobes that
// a consumer must capture in the cycle they are high (period is held until
// the next update).
module ad_pulse_gen
   import ad_pulse_gen_pkg::*;
#(
   parameter int HYST    = 8,
   parameter int MIN_LEN = 4,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             ad_clk,
   input  logic             rst,
   input  logic [AD_DW-1:0] ad_data,
   input  logic [AD_DW-1:0] trig_level,
   output logic             ad_pulse,
   output logic             rise_stb,
   output logic [31:0]      period,
   output logic             period_valid,
   output logic             no_signal,
   output pulse_state_t     dbg_state
);

   localparam int            TW      = $clog2(TIMEOUT) + 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [7:0]    LEN     = 8'(MIN_LEN);

   pulse_state_t    state;
   pulse_state_t    state_nx;
   logic [7:0]      cnt;
   logic [7:0]      cnt_nx;
   logic [7:0]      cnt_inc;
   logic            rise_conf;
   logic            timeout_hit;
   logic            timeout_fire;

   logic [8:0]      hi_sum;
   logic [8:0]      lo_dif;
   logic [7:0]      th_hi;
   logic [7:0]      th_lo;
   logic            rise_q;
   logic            fall_q;

   logic [31:0]     per_cnt;
   logic [31:0]     per_inc;
   logic            armed;
   logic [TW-1:0]   tcnt;

   // Saturating thresholds: a borrow or carry in bit 8 clips to the rail.
   assign hi_sum  = {1'b0, trig_level} + 9'(HYST);
   assign lo_dif  = {1'b0, trig_level} - 9'(HYST);
   assign th_hi   = hi_sum[8] ? 8'hFF : hi_sum[7:0];
   assign th_lo   = lo_dif[8] ? 8'h00 : lo_dif[7:0];
   assign rise_q  = (ad_data >= th_hi);
   assign fall_q  = (ad_data <= th_lo);

   assign cnt_inc = cnt + 8'd1;
   assign per_inc = (per_cnt == 32'hFFFF_FFFF) ? per_cnt : per_cnt + 32'd1;

   // Timeout fires once per episode; while no_signal is high the counter is
   // parked at its last value so the FSM is not forced to LOW every cycle.
   assign timeout_hit = (tcnt == TO_LAST) && !no_signal;

   assign dbg_state   = state;

   // Next-state logic: edge qualification with MIN_LEN debounce, timeout override.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      rise_conf    = 1'b0;
      timeout_fire = 1'b0;
      case (state)
         ST_LOW: begin
            if (rise_q) begin
               if (MIN_LEN == 1) begin
                  state_nx  = ST_HIGH;
                  cnt_nx    = 8'd0;
                  rise_conf = 1'b1;
               end else begin
                  state_nx = ST_RISE_CHK;
                  cnt_nx   = 8'd1;
               end
            end
         end
         ST_RISE_CHK: begin
            if (rise_q) begin
               if (cnt_inc == LEN) begin
                  state_nx  = ST_HIGH;
                  cnt_nx    = 8'd0;
                  rise_conf = 1'b1;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end else begin
               state_nx = ST_LOW;
               cnt_nx   = 8'd0;
            end
         end
         ST_HIGH: begin
            if (fall_q) begin
               if (MIN_LEN == 1) begin
                  state_nx = ST_LOW;
                  cnt_nx   = 8'd0;
               end else begin
                  state_nx = ST_FALL_CHK;
                  cnt_nx   = 8'd1;
               end
            end
         end
         ST_FALL_CHK: begin
            if (fall_q) begin
               if (cnt_inc == LEN) begin
                  state_nx = ST_LOW;
                  cnt_nx   = 8'd0;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end else begin
               state_nx = ST_HIGH;
               cnt_nx   = 8'd0;
            end
         end
         default: begin
            state_nx = ST_LOW;
            cnt_nx   = 8'd0;
         end
      endcase
      // A confirmed rise in the same cycle beats the timeout.
      if (timeout_hit && !rise_conf) begin
         timeout_fire = 1'b1;
         state_nx     = ST_LOW;
         cnt_nx       = 8'd0;
      end
   end

   // FSM state, debounce count and the registered pulse/strobe outputs.
   always_ff @(posedge ad_clk) begin
      if (rst) begin
         state    <= ST_LOW;
         cnt      <= 8'd0;
         ad_pulse <= 1'b0;
         rise_stb <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         ad_pulse <= (state_nx == ST_HIGH) || (state_nx == ST_FALL_CHK);
         rise_stb <= rise_conf;
      end
   end

   // Period measurement; the first rise of an episode only restarts the counter.
   always_ff @(posedge ad_clk) begin
      if (rst) begin
         per_cnt      <= 32'd0;
         period       <= 32'd0;
         period_valid <= 1'b0;
         armed        <= 1'b0;
      end else begin
         period_valid <= rise_conf && armed;
         if (rise_conf) begin
            if (armed) begin
               period <= per_inc;
            end
            per_cnt <= 32'd0;
            armed   <= 1'b1;
         end else begin
            per_cnt <= per_inc;
            if (timeout_fire) begin
               armed <= 1'b0;
            end
         end
      end
   end

   // Timeout counter and no_signal flag.
   always_ff @(posedge ad_clk) begin
      if (rst) begin
         tcnt      <= '0;
         no_signal <= 1'b0;
      end else begin
         if (rise_conf) begin
            tcnt      <= '0;
            no_signal <= 1'b0;
         end else begin
            if (tcnt != TO_LAST) begin
               tcnt <= tcnt + 1'b1;
            end
            if (timeout_fire) begin
               no_signal <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ad_pulse_gen.sv
// Directed bench for ad_pulse_gen: square wave, glitches, noisy ramp, reset in
// FALL_CHK, timeout (separate TIMEOUT=64 instance) and saturated thresholds.
module tb_ad_pulse_gen;
   import ad_pulse_gen_pkg::*;

   logic         ad_clk;
   logic         rst;
   logic [7:0]   ad_data;
   logic [7:0]   trig_level;

   logic         pulse, rise, pv, ns;
   logic [31:0]  per;
   pulse_state_t st;

   logic         pulse_t, rise_t, pv_t, ns_t;
   logic [31:0]  per_t;
   pulse_state_t st_t;

   int total = 0;
   int bad   = 0;

   // clock / reset
   initial ad_clk = 1'b0;
   always #5 ad_clk = ~ad_clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   ad_pulse_gen #(.HYST(8), .MIN_LEN(4), .TIMEOUT(1000)) u_dut (
      .ad_clk(ad_clk), .rst(rst), .ad_data(ad_data), .trig_level(trig_level),
      .ad_pulse(pulse), .rise_stb(rise), .period(per), .period_valid(pv),
      .no_signal(ns), .dbg_state(st)
   );

   ad_pulse_gen #(.HYST(8), .MIN_LEN(4), .TIMEOUT(64)) u_to (
      .ad_clk(ad_clk), .rst(rst), .ad_data(ad_data), .trig_level(trig_level),
      .ad_pulse(pulse_t), .rise_stb(rise_t), .period(per_t), .period_valid(pv_t),
      .no_signal(ns_t), .dbg_state(st_t)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // driver: present one sample, sample outputs 1 time unit after the edge
   task automatic step(input logic [7:0] d);
      ad_data = d;
      @(posedge ad_clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(ad_data);
      step(ad_data);
      rst = 1'b0;
   endtask

   initial begin
      int nr;
      int nf;
      logic prev;
      rst        = 1'b1;
      ad_data    = 8'd50;
      trig_level = 8'd128;
      do_reset();
      chk("rst_pulse", pulse, 0);
      chk("rst_rise", rise, 0);
      chk("rst_period", per, 0);
      chk("rst_pv", pv, 0);
      chk("rst_ns", ns, 0);
      chk("rst_state", st, ST_LOW);

      // square wave 200/50, 100 cycles per phase
      for (int i = 0; i < 100; i++) begin
         step(8'd50);
         chk("sq_low0", pulse, 0);
      end
      for (int h = 0; h < 2; h++) begin
         for (int i = 0; i < 100; i++) begin
            step(8'd200);
            chk("sq_hi_pulse", pulse, (i >= 3));
            chk("sq_hi_rise", rise, (i == 3));
            if (i == 3) begin
               chk("sq_pv", pv, (h == 1));
               chk("sq_period", per, (h == 1) ? 200 : 0);
            end else begin
               chk("sq_pv_idle", pv, 0);
            end
         end
         for (int i = 0; i < 100; i++) begin
            step(8'd50);
            chk("sq_lo_pulse", pulse, (i < 3));
         end
      end

      // glitch and short burst during the low phase
      step(8'd200);
      chk("gl_state", st, ST_RISE_CHK);
      chk("gl_pulse", pulse, 0);
      for (int i = 0; i < 5; i++) begin
         step(8'd50);
         chk("gl_pulse_lo", pulse, 0);
      end
      for (int i = 0; i < 3; i++) begin
         step(8'd140);
         chk("bu_pulse", pulse, 0);
         chk("bu_rise", rise, 0);
      end
      for (int i = 0; i < 5; i++) begin
         step(8'd50);
         chk("bu_after", pulse, 0);
      end

      // noisy ramp 0->255->0, two cycles
      nr   = 0;
      nf   = 0;
      prev = pulse;
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 512; k++) begin
            int base;
            int v;
            base = (k < 256) ? k : 511 - k;
            v = base + ((k * 7) % 11) - 5;
            if (v < 0) v = 0;
            if (v > 255) v = 255;
            step(8'(v));
            if (rise) nr++;
            if (prev && !pulse) nf++;
            prev = pulse;
         end
      end
      chk("ramp_rises", nr, 2);
      chk("ramp_falls", nf, 2);
      chk("ramp_end", pulse, 0);

      // reset asserted while in FALL_CHK
      for (int i = 0; i < 4; i++) step(8'd200);
      chk("rf_rise", rise, 1);
      chk("rf_pv", pv, 1);
      for (int i = 0; i < 3; i++) step(8'd50);
      chk("rf_state", st, ST_FALL_CHK);
      chk("rf_pulse", pulse, 1);
      rst = 1'b1;
      step(8'd50);
      rst = 1'b0;
      chk("rf_r_pulse", pulse, 0);
      chk("rf_r_rise", rise, 0);
      chk("rf_r_period", per, 0);
      chk("rf_r_pv", pv, 0);
      chk("rf_r_ns", ns, 0);
      chk("rf_r_state", st, ST_LOW);
      for (int i = 0; i < 3; i++) step(8'd50);
      chk("rf_low", st, ST_LOW);
      for (int i = 0; i < 4; i++) begin
         step(8'd200);
         chk("rf_re_pulse", pulse, (i == 3));
      end
      chk("rf_re_pv", pv, 0);

      // timeout on the TIMEOUT=64 instance
      do_reset();
      for (int i = 0; i < 4; i++) step(8'd200);
      chk("to_rise", rise_t, 1);
      chk("to_pv_first", pv_t, 0);
      chk("to_main_pv_first", pv, 0);
      for (int j = 1; j <= 64; j++) begin
         step(8'd50);
         chk("to_ns", ns_t, (j == 64));
         if (j == 64) begin
            chk("to_pulse", pulse_t, 0);
            chk("to_state", st_t, ST_LOW);
         end
      end
      for (int i = 0; i < 20; i++) step(8'd50);
      chk("to_ns_hold", ns_t, 1);
      for (int i = 0; i < 4; i++) begin
         step(8'd200);
         if (i == 2) chk("to_ns_pre", ns_t, 1);
      end
      chk("to_rise2", rise_t, 1);
      chk("to_ns_clr", ns_t, 0);
      chk("to_pv2", pv_t, 0);
      chk("to_main_pv", pv, 1);
      chk("to_main_per", per, 88);

      // th_lo saturates at 0
      trig_level = 8'd3;
      do_reset();
      for (int i = 0; i < 4; i++) step(8'd20);
      chk("lo_rise", rise, 1);
      for (int i = 0; i < 10; i++) begin
         step(8'd1);
         chk("lo_one", pulse, 1);
      end
      for (int i = 0; i < 3; i++) step(8'd0);
      chk("lo_chk", st, ST_FALL_CHK);
      step(8'd1);
      chk("lo_abort", st, ST_HIGH);
      chk("lo_abort_p", pulse, 1);
      for (int i = 0; i < 4; i++) begin
         step(8'd0);
         chk("lo_fall", pulse, (i < 3));
      end

      // th_hi saturates at 255
      trig_level = 8'd250;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(8'd254);
         chk("hi_254", pulse, 0);
      end
      chk("hi_state", st, ST_LOW);
      for (int i = 0; i < 4; i++) begin
         step(8'd255);
         chk("hi_255", pulse, (i >= 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
